// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID->EX pipeline register: control bit layout and widths.
package id_ex_stage_pkg;

  localparam int unsigned CTRL_W  = 8;
  localparam int unsigned FUNCT_W = 10;
  localparam int unsigned REG_AW  = 5;

  localparam int unsigned CTRL_REGWRITE = 7;
  localparam int unsigned CTRL_MEMTOREG = 6;
  localparam int unsigned CTRL_MEMREAD  = 5;
  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_BRANCH   = 3;
  localparam int unsigned CTRL_ALUSRC   = 2;
  localparam int unsigned CTRL_ALUOP_HI = 1;
  localparam int unsigned CTRL_ALUOP_LO = 0;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // A destination register matches a source only when it is not x0.
  function automatic logic rd_match(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/WB/EX signal bundle of the ID->EX stage; master drives ID/WB side, slave is the stage.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic                id_valid_i;
  logic [REG_AW-1:0]   RS1addr_i;
  logic [REG_AW-1:0]   RS2addr_i;
  logic [XLEN-1:0]     RS1data_i;
  logic [XLEN-1:0]     RS2data_i;
  logic                use_rs1_i;
  logic                use_rs2_i;
  logic [REG_AW-1:0]   RDaddr_i;
  logic [XLEN-1:0]     imm_i;
  logic [FUNCT_W-1:0]  funct_i;
  logic [CTRL_W-1:0]   ctrl_i;
  logic                wb_RegWrite_i;
  logic [REG_AW-1:0]   wb_RDaddr_i;
  logic [XLEN-1:0]     wb_RDdata_i;
  logic                flush_i;
  logic                ex_stall_i;

  logic                stall_o;
  logic                ex_valid_o;
  logic [XLEN-1:0]     ex_RS1data_o;
  logic [XLEN-1:0]     ex_RS2data_o;
  logic [REG_AW-1:0]   ex_RS1addr_o;
  logic [REG_AW-1:0]   ex_RS2addr_o;
  logic [REG_AW-1:0]   ex_RDaddr_o;
  logic [XLEN-1:0]     ex_imm_o;
  logic [FUNCT_W-1:0]  ex_funct_o;
  logic [CTRL_W-1:0]   ex_ctrl_o;
  logic [CNT_W-1:0]    bubble_cnt_o;

  modport master (
    output id_valid_i, RS1addr_i, RS2addr_i, RS1data_i, RS2data_i, use_rs1_i, use_rs2_i,
           RDaddr_i, imm_i, funct_i, ctrl_i, wb_RegWrite_i, wb_RDaddr_i, wb_RDdata_i,
           flush_i, ex_stall_i,
    input  stall_o, ex_valid_o, ex_RS1data_o, ex_RS2data_o, ex_RS1addr_o, ex_RS2addr_o,
           ex_RDaddr_o, ex_imm_o, ex_funct_o, ex_ctrl_o, bubble_cnt_o
  );

  modport slave (
    input  id_valid_i, RS1addr_i, RS2addr_i, RS1data_i, RS2data_i, use_rs1_i, use_rs2_i,
           RDaddr_i, imm_i, funct_i, ctrl_i, wb_RegWrite_i, wb_RDaddr_i, wb_RDdata_i,
           flush_i, ex_stall_i,
    output stall_o, ex_valid_o, ex_RS1data_o, ex_RS2data_o, ex_RS1addr_o, ex_RS2addr_o,
           ex_RDaddr_o, ex_imm_o, ex_funct_o, ex_ctrl_o, bubble_cnt_o
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard: a valid load in EX whose rd is read by the valid instruction in ID.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic              use_rs1_i,
  input  logic              use_rs2_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              lu_c
);

  always_comb begin
    lu_c = ex_valid_i & ex_mem_read_i & id_valid_i &
           ((use_rs1_i & rd_match(ex_rd_i, rs1_i)) |
            (use_rs2_i & rd_match(ex_rd_i, rs2_i)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with WB->ID bypass, load-use stall/bubble, flush and bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);

  logic                valid_q, valid_d;
  logic [XLEN-1:0]     rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]     rs2_data_q, rs2_data_d;
  logic [REG_AW-1:0]   rs1_addr_q, rs1_addr_d;
  logic [REG_AW-1:0]   rs2_addr_q, rs2_addr_d;
  logic [REG_AW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]     imm_q, imm_d;
  logic [FUNCT_W-1:0]  funct_q, funct_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [XLEN-1:0]     op1_c, op2_c;
  logic                lu_c;

  // Register file has no internal bypass, so a same-cycle WB write is forwarded here.
  always_comb begin
    op1_c = bus.RS1data_i;
    op2_c = bus.RS2data_i;
    if (bus.wb_RegWrite_i && rd_match(bus.wb_RDaddr_i, bus.RS1addr_i)) op1_c = bus.wb_RDdata_i;
    if (bus.wb_RegWrite_i && rd_match(bus.wb_RDaddr_i, bus.RS2addr_i)) op2_c = bus.wb_RDdata_i;
  end

  id_ex_stage_hazard_detect u_hazard_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q[CTRL_MEMREAD]),
    .ex_rd_i       (rd_addr_q),
    .id_valid_i    (bus.id_valid_i),
    .use_rs1_i     (bus.use_rs1_i),
    .use_rs2_i     (bus.use_rs2_i),
    .rs1_i         (bus.RS1addr_i),
    .rs2_i         (bus.RS2addr_i),
    .lu_c          (lu_c)
  );

  assign bus.stall_o = rst_i & (lu_c | bus.ex_stall_i) & ~bus.flush_i;

  // Priority: flush bubble, downstream hold, load-use bubble, normal capture.
  always_comb begin
    valid_d    = valid_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    imm_d      = imm_q;
    funct_d    = funct_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
    end else if (bus.ex_stall_i) begin
      valid_d = valid_q;
    end else if (lu_c) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      valid_d    = bus.id_valid_i;
      ctrl_d     = bus.id_valid_i ? bus.ctrl_i : CTRL_BUBBLE;
      rs1_data_d = op1_c;
      rs2_data_d = op2_c;
      rs1_addr_d = bus.RS1addr_i;
      rs2_addr_d = bus.RS2addr_i;
      rd_addr_d  = bus.RDaddr_i;
      imm_d      = bus.imm_i;
      funct_d    = bus.funct_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      imm_q      <= '0;
      funct_q    <= '0;
      ctrl_q     <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      imm_q      <= imm_d;
      funct_q    <= funct_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ex_valid_o   = valid_q;
  assign bus.ex_RS1data_o = rs1_data_q;
  assign bus.ex_RS2data_o = rs2_data_q;
  assign bus.ex_RS1addr_o = rs1_addr_q;
  assign bus.ex_RS2addr_o = rs2_addr_q;
  assign bus.ex_RDaddr_o  = rd_addr_q;
  assign bus.ex_imm_o     = imm_q;
  assign bus.ex_funct_o   = funct_q;
  assign bus.ex_ctrl_o    = ctrl_q;
  assign bus.bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, bypass, load-use, flush, hold, counter saturation.
module tb_id_ex_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  int   vec  = 0;
  int   miss = 0;
  int   exp_cnt;

  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic id_instr(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                          input logic u1, input logic [4:0] rs2, input logic [31:0] d2,
                          input logic u2, input logic [4:0] rd, input logic [31:0] imm,
                          input logic [9:0] funct, input logic [7:0] ctrl);
    bus.id_valid_i = v;
    bus.RS1addr_i  = rs1;
    bus.RS1data_i  = d1;
    bus.use_rs1_i  = u1;
    bus.RS2addr_i  = rs2;
    bus.RS2data_i  = d2;
    bus.use_rs2_i  = u2;
    bus.RDaddr_i   = rd;
    bus.imm_i      = imm;
    bus.funct_i    = funct;
    bus.ctrl_i     = ctrl;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    bus.wb_RegWrite_i = we;
    bus.wb_RDaddr_i   = rd;
    bus.wb_RDdata_i   = d;
  endtask

  initial begin
    // Reset with a live instruction and a downstream stall present.
    rst_i = 1'b0;
    id_instr(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'h4, 10'h5, 8'hFF);
    wb(1'b0, 5'd0, 32'h0);
    bus.flush_i    = 1'b0;
    bus.ex_stall_i = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(bus.ex_valid_o), 32'h0);
    chk("rst_ctrl", 32'(bus.ex_ctrl_o), 32'h0);
    chk("rst_cnt", 32'(bus.bubble_cnt_o), 32'h0);
    chk("rst_stall", 32'(bus.stall_o), 32'h0);
    chk("rst_rd", 32'(bus.ex_RDaddr_o), 32'h0);
    rst_i = 1'b1;
    bus.ex_stall_i = 1'b0;

    // Same-cycle WB write to x5 is forwarded into rs1.
    id_instr(1'b1, 5'd5, 32'h0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h123, 10'h2AB, 8'h86);
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    chk("byp_rs1data", bus.ex_RS1data_o, 32'hDEADBEEF);
    chk("byp_rs2data", bus.ex_RS2data_o, 32'h66);
    chk("byp_valid", 32'(bus.ex_valid_o), 32'h1);
    chk("byp_ctrl", 32'(bus.ex_ctrl_o), 32'h86);
    chk("byp_rd", 32'(bus.ex_RDaddr_o), 32'h7);
    chk("byp_rs1addr", 32'(bus.ex_RS1addr_o), 32'h5);
    chk("byp_imm", bus.ex_imm_o, 32'h123);
    chk("byp_funct", 32'(bus.ex_funct_o), 32'h2AB);

    // WB write to x0 must not be forwarded.
    id_instr(1'b1, 5'd0, 32'h1111, 1'b1, 5'd0, 32'h2222, 1'b1, 5'd8, 32'h0, 10'h0, 8'h82);
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    chk("x0_rs1data", bus.ex_RS1data_o, 32'h1111);
    chk("x0_rs2data", bus.ex_RS2data_o, 32'h2222);

    // Matching address without RegWrite is not forwarded.
    id_instr(1'b1, 5'd5, 32'h5555, 1'b1, 5'd9, 32'h9999, 1'b1, 5'd8, 32'h0, 10'h0, 8'h82);
    wb(1'b0, 5'd5, 32'hCAFEF00D);
    step();
    chk("nowe_rs1data", bus.ex_RS1data_o, 32'h5555);
    wb(1'b0, 5'd0, 32'h0);

    // Load-use: lw x3 then add reading x3 via rs2.
    id_instr(1'b1, 5'd1, 32'h10, 1'b1, 5'd0, 32'h0, 1'b0, 5'd3, 32'h4, 10'h2, 8'hE4);
    step();
    id_instr(1'b1, 5'd1, 32'h10, 1'b1, 5'd3, 32'h30, 1'b1, 5'd4, 32'h0, 10'h0, 8'h82);
    settle();
    chk("lu_stall", 32'(bus.stall_o), 32'h1);
    step();
    chk("lu_bubble_valid", 32'(bus.ex_valid_o), 32'h0);
    chk("lu_bubble_ctrl", 32'(bus.ex_ctrl_o), 32'h0);
    chk("lu_cnt", 32'(bus.bubble_cnt_o), 32'h1);
    chk("lu_stall_drop", 32'(bus.stall_o), 32'h0);
    step();
    chk("lu_add_valid", 32'(bus.ex_valid_o), 32'h1);
    chk("lu_add_ctrl", 32'(bus.ex_ctrl_o), 32'h82);
    chk("lu_add_rd", 32'(bus.ex_RDaddr_o), 32'h4);
    chk("lu_cnt_hold", 32'(bus.bubble_cnt_o), 32'h1);

    // Same sequence but rs2 not used: no stall, add enters directly.
    id_instr(1'b1, 5'd1, 32'h10, 1'b1, 5'd0, 32'h0, 1'b0, 5'd3, 32'h4, 10'h2, 8'hE4);
    step();
    id_instr(1'b1, 5'd1, 32'h10, 1'b1, 5'd3, 32'h30, 1'b0, 5'd4, 32'h0, 10'h0, 8'h82);
    settle();
    chk("nolu_stall", 32'(bus.stall_o), 32'h0);
    step();
    chk("nolu_valid", 32'(bus.ex_valid_o), 32'h1);
    chk("nolu_ctrl", 32'(bus.ex_ctrl_o), 32'h82);
    chk("nolu_cnt", 32'(bus.bubble_cnt_o), 32'h1);

    // Load to x0 never causes a hazard.
    id_instr(1'b1, 5'd1, 32'h10, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h4, 10'h2, 8'hE4);
    step();
    id_instr(1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 1'b1, 5'd4, 32'h0, 10'h0, 8'h82);
    settle();
    chk("x0_lu_stall", 32'(bus.stall_o), 32'h0);

    // Flush overrides downstream stall and load-use.
    id_instr(1'b1, 5'd1, 32'h10, 1'b1, 5'd0, 32'h0, 1'b0, 5'd3, 32'h4, 10'h2, 8'hE4);
    step();
    id_instr(1'b1, 5'd3, 32'h30, 1'b1, 5'd0, 32'h0, 1'b0, 5'd4, 32'h0, 10'h0, 8'h82);
    bus.ex_stall_i = 1'b1;
    bus.flush_i    = 1'b1;
    settle();
    chk("flush_stall", 32'(bus.stall_o), 32'h0);
    step();
    chk("flush_valid", 32'(bus.ex_valid_o), 32'h0);
    chk("flush_ctrl", 32'(bus.ex_ctrl_o), 32'h0);
    chk("flush_cnt", 32'(bus.bubble_cnt_o), 32'h1);
    bus.ex_stall_i = 1'b0;
    bus.flush_i    = 1'b0;

    // Downstream hold for three cycles, then capture the pending instruction.
    id_instr(1'b1, 5'd2, 32'hAAAA, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 32'h77, 10'h11, 8'h80);
    step();
    id_instr(1'b1, 5'd2, 32'hBBBB, 1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 32'h88, 10'h22, 8'h81);
    bus.ex_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_stall", 32'(bus.stall_o), 32'h1);
      step();
      chk("hold_rd", 32'(bus.ex_RDaddr_o), 32'h9);
      chk("hold_imm", bus.ex_imm_o, 32'h77);
      chk("hold_data", bus.ex_RS1data_o, 32'hAAAA);
      chk("hold_ctrl", 32'(bus.ex_ctrl_o), 32'h80);
      chk("hold_funct", 32'(bus.ex_funct_o), 32'h11);
      chk("hold_valid", 32'(bus.ex_valid_o), 32'h1);
    end
    bus.ex_stall_i = 1'b0;
    settle();
    chk("rel_stall", 32'(bus.stall_o), 32'h0);
    step();
    chk("rel_rd", 32'(bus.ex_RDaddr_o), 32'hA);
    chk("rel_imm", bus.ex_imm_o, 32'h88);
    chk("rel_data", bus.ex_RS1data_o, 32'hBBBB);
    chk("rel_ctrl", 32'(bus.ex_ctrl_o), 32'h81);

    // Invalid ID slot enters EX with zero controls.
    id_instr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 32'h0, 10'h0, 8'hFF);
    step();
    chk("inv_valid", 32'(bus.ex_valid_o), 32'h0);
    chk("inv_ctrl", 32'(bus.ex_ctrl_o), 32'h0);

    // 17 load-use bubbles: counter saturates at all-ones.
    exp_cnt = 1;
    for (int i = 0; i < 17; i++) begin
      id_instr(1'b1, 5'd1, 32'h10, 1'b1, 5'd0, 32'h0, 1'b0, 5'd3, 32'h4, 10'h2, 8'hE4);
      step();
      id_instr(1'b1, 5'd3, 32'h30, 1'b1, 5'd0, 32'h0, 1'b0, 5'd4, 32'h0, 10'h0, 8'h82);
      step();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      chk("sat_cnt", 32'(bus.bubble_cnt_o), 32'(exp_cnt));
    end
    chk("sat_final", 32'(bus.bubble_cnt_o), 32'hF);

    // Reset in the middle of a load-use stall empties the pipeline.
    id_instr(1'b1, 5'd1, 32'h10, 1'b1, 5'd0, 32'h0, 1'b0, 5'd3, 32'h4, 10'h2, 8'hE4);
    step();
    id_instr(1'b1, 5'd3, 32'h30, 1'b1, 5'd0, 32'h0, 1'b0, 5'd4, 32'h0, 10'h0, 8'h82);
    settle();
    chk("mid_stall", 32'(bus.stall_o), 32'h1);
    rst_i = 1'b0;
    settle();
    chk("mid_rst_stall", 32'(bus.stall_o), 32'h0);
    step();
    rst_i = 1'b1;
    settle();
    chk("post_rst_valid", 32'(bus.ex_valid_o), 32'h0);
    chk("post_rst_cnt", 32'(bus.bubble_cnt_o), 32'h0);
    chk("post_rst_stall", 32'(bus.stall_o), 32'h0);
    step();
    chk("post_rst_add", 32'(bus.ex_ctrl_o), 32'h82);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID→EX pipeline register of the 5-stage RISC-V core; sits directly downstream of the register file.
- Captures register-file read data, immediate and decode controls, and presents them to EX.
- The register file has no internal write-to-read bypass, so this block provides the WB→ID bypass.
- Also detects load-use hazards (stall + bubble), applies branch flushes, and counts inserted bubbles.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clk_i.
- id_valid_i  in  1  ID holds a real instruction.
- RS1addr_i / RS2addr_i  in  5 each  source register addresses decoded in ID.
- RS1data_i / RS2data_i  in  XLEN each  register-file read data.
- use_rs1_i / use_rs2_i  in  1 each  instruction actually reads rs1 / rs2.
- RDaddr_i  in  5  destination address.
- imm_i  in  XLEN  sign-extended immediate.
- funct_i  in  10  {funct7, funct3}.
- ctrl_i  in  8  {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, ALUOp[1:0]}.
- wb_RegWrite_i  in  1  WB writes this cycle.
- wb_RDaddr_i  in  5  WB destination address.
- wb_RDdata_i  in  XLEN  WB write data.
- flush_i  in  1  taken branch/jump resolved downstream.
- ex_stall_i  in  1  EX cannot accept; hold.
- stall_o  out  1  hold PC and IF/ID.
- ex_valid_o  out  1  EX holds a real instruction.
- ex_RS1data_o / ex_RS2data_o  out  XLEN each  latched operands.
- ex_RS1addr_o / ex_RS2addr_o / ex_RDaddr_o  out  5 each  latched addresses.
- ex_imm_o  out  XLEN  latched immediate.
- ex_funct_o  out  10  latched funct field.
- ex_ctrl_o  out  8  latched controls; zero when ex_valid_o = 0.
- bubble_cnt_o  out  CNT_W  load-use bubbles inserted since reset.

Behaviour:
- Reset (rst_i = 0 at posedge): every registered output is 0, including ex_valid_o, ex_ctrl_o and bubble_cnt_o. stall_o is combinational and is forced to 0 while rst_i = 0.
- Bypass (combinational):
  - op1 = wb_RDdata_i when wb_RegWrite_i = 1, wb_RDaddr_i != 0 and wb_RDaddr_i == RS1addr_i; otherwise RS1data_i.
  - op2 is formed the same way from RS2addr_i / RS2data_i.
- Load-use hazard (combinational), lu = 1 when all of the following hold:
  - ex_valid_o = 1 and ex_ctrl_o.MemRead = 1;
  - ex_RDaddr_o != 0 and id_valid_i = 1;
  - (use_rs1_i and RS1addr_i == ex_RDaddr_o) or (use_rs2_i and RS2addr_i == ex_RDaddr_o).
- stall_o = (lu | ex_stall_i) & ~flush_i.
- Register update priority at each posedge:
  1. Reset: as above.
  2. flush_i = 1: load a bubble (ex_valid_o = 0, ex_ctrl_o = 0; data fields don't-care, hold them). Flush overrides ex_stall_i and lu.
  3. ex_stall_i = 1: hold all EX registers unchanged.
  4. lu = 1: load a bubble; bubble_cnt_o increments, saturating at all-ones.
  5. Otherwise: load ex_valid_o = id_valid_i; ex_ctrl_o = ctrl_i if id_valid_i else 0; op1/op2, addresses, imm and funct captured.
- Latency: exactly one cycle ID→EX. A load-use hazard costs exactly one bubble; lu deasserts in the cycle after the bubble because the load has left EX.
- rd = x0: never triggers bypass or hazard.
- WB write and ID read of the same register in the same cycle: the bypass supplies the new value.
- Reset mid-stall: the pipeline empties, and stall_o = 0 in the first cycle after reset.
- bubble_cnt_o: counts only load-use bubbles. Flush bubbles and holds do not count it.

Decomposition:
- Shared package holds:
  - control bit-index constants (CTRL_REGWRITE=7 … CTRL_ALUOP=1:0);
  - CTRL_W=8, FUNCT_W=10;
  - a localparam for the bubble pattern (all-zero controls).
- One sub-module, hazard_detect: purely combinational computation of lu. Bypass muxes stay inline.

Test Plan:
- Reset: hold rst_i = 0 for 2 cycles with id_valid_i = 1 and ctrl_i = 8'hFF → ex_valid_o = 0, ex_ctrl_o = 0, bubble_cnt_o = 0, stall_o = 0.
- WB bypass:
  - Same-cycle write: wb writes x5 = 32'hDEADBEEF while ID reads rs1 = x5 with RS1data_i = 32'h0 → next cycle ex_RS1data_o = 32'hDEADBEEF.
  - Write to x0: wb_RDaddr_i = 0 → ex_RS1data_o = RS1data_i.
- Load-use:
  - Case: lw x3 in EX, ID add uses rs2 = x3 → stall_o = 1 for 1 cycle; EX gets bubble (ex_valid_o = 0); the add enters EX the following cycle; bubble_cnt_o = 1.
  - No-hazard variant: same sequence with use_rs2_i = 0 → no stall.
- Flush priority: flush_i = 1 together with ex_stall_i = 1 and a load-use condition → ex_valid_o = 0 next cycle, stall_o = 0, bubble_cnt_o unchanged.
- Downstream hold: ex_stall_i = 1 for 3 cycles → all ex_* outputs constant, stall_o = 1 throughout; on release, the pending ID instruction is captured in one cycle.
- Counter saturation: CNT_W = 4, force 17 load-use bubbles → bubble_cnt_o stops at 4'hF.
